// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and address helper for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_AW    = 10;
  localparam int DMEM_DW    = 32;
  localparam int OFFSET_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } dmem_state_e;

  // Word address is the low bits of base+offset; carries out of bit 9 are dropped.
  function automatic logic [DMEM_AW-1:0] addr_wrap(input logic [DMEM_AW-1:0] base,
                                                    input logic [DMEM_AW-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant logic for the data-memory arbiter (module rr_arb2).
// Define DMEM_ARB_FIXED_PRIO_EN to make requester 0 win every contention.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // Contention: the requester that did not win last time goes next.
      2'b11:   o_gnt = (FIXED_PRIO || i_last) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 1024x32 data memory.
// One operation at a time: handshake, ISSUE (mem strobe), CAPTURE, then response.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [63:0] req_wdata,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  dmem_state_e r_state, w_state_nxt;

  logic [1:0]         w_gnt;
  logic               w_hs;
  logic               w_win;
  logic               w_we_sel;
  logic [DMEM_AW-1:0] w_addr_sel;
  logic [DMEM_DW-1:0] w_wdata_sel;
  logic               w_unused;

  logic               r_last_grant;
  logic               r_owner;
  logic               r_we;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [DMEM_AW-1:0] r_mem_addr;
  logic [DMEM_DW-1:0] r_mem_wdata;
  logic [1:0]         r_resp_valid;
  logic [DMEM_DW-1:0] r_resp_rdata;

  rr_arb2 u_arb (
    .i_req  (req_valid),
    .i_last (r_last_grant),
    .o_gnt  (w_gnt)
  );

  // Ready is gated by the raw reset so nothing is accepted while it is held.
  assign req_ready = (r_state == ST_IDLE && reset) ? w_gnt : 2'b00;
  assign w_hs      = |(req_valid & req_ready);
  assign w_win     = w_gnt[1];

  assign w_we_sel    = w_win ? req_we[1] : req_we[0];
  assign w_wdata_sel = w_win ? req_wdata[63:32] : req_wdata[31:0];
  assign w_addr_sel  = w_win ? addr_wrap(req_base[41:32], req_offset[25:16])
                             : addr_wrap(req_base[9:0],   req_offset[9:0]);

  assign w_unused = ^{req_base[63:42], req_base[31:10],
                      req_offset[31:26], req_offset[15:10]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_hs) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
    end else begin
      // Strobe lands in the ISSUE cycle, which is always the cycle after handshake.
      r_mem_en     <= w_hs;
      r_mem_we     <= w_hs & w_we_sel;
      r_resp_valid <= 2'b00;
      if (w_hs) begin
        r_mem_addr   <= w_addr_sel;
        r_mem_wdata  <= w_wdata_sel;
        r_we         <= w_we_sel;
        r_owner      <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == ST_CAPTURE) begin
        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
        r_resp_rdata <= r_we ? '0 : mem_rdata;
      end
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 synchronous memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_base;
  logic [31:0] req_offset;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] mem [1024];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [31:0] base,
                         input logic [15:0] off, input logic [31:0] wd);
    req_we[id]             = we;
    req_base[id*32 +: 32]  = base;
    req_offset[id*16 +: 16] = off;
    req_wdata[id*32 +: 32] = wd;
  endtask

  // Called on a negedge with the FSM idle; returns on the response negedge.
  task automatic do_op(input string tag, input int id, input logic we,
                       input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [9:0] ea, input logic [31:0] er);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    set_req(id, we, base, off, wd);
    req_valid = oh;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, ".mem_en"}, 32'(mem_en), 32'd1);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wd);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".mem_en_off"}, 32'(mem_en), 32'd0);
    chk({tag, ".resp_early"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(oh));
    chk({tag, ".resp_rdata"}, resp_rdata, er);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_g[4];
    logic [1:0] oh;
    logic [31:0] erd;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[3] = 32'd7;
    mem[4] = 32'h0000_1234;

    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_we     = 2'b00;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;

    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    do_op("ld0", 0, 1'b0, 32'd1, 16'd2, 32'd0, 10'd3, 32'd7);
    do_op("st1", 1, 1'b1, 32'd1020, 16'd10, 32'hDEAD_BEEF, 10'd6, 32'd0);
    do_op("ld6", 0, 1'b0, 32'd6, 16'd0, 32'd0, 10'd6, 32'hDEAD_BEEF);
    do_op("wrap", 1, 1'b0, 32'h0000_0405, 16'hFFFF, 32'd0, 10'd4, 32'h0000_1234);

    // Last winner was requester 1, so contention starts with requester 0.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b0, 32'd3, 16'd0, 32'd0);
    set_req(1, 1'b0, 32'd6, 16'd0, 32'd0);
    req_valid = 2'b11;
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) req_valid = 2'b00;
      #1;
      if (c % 3 == 0 && c < 12) begin
        oh = (exp_g[c/3] == 1) ? 2'b10 : 2'b01;
        chk($sformatf("cont.grant%0d", c/3), 32'(req_ready), 32'(oh));
      end else begin
        chk($sformatf("cont.busy_ready%0d", c), 32'(req_ready), 32'd0);
      end
      if (c % 3 == 0 && c > 0) begin
        oh  = (exp_g[c/3-1] == 1) ? 2'b10 : 2'b01;
        erd = (exp_g[c/3-1] == 1) ? 32'hDEAD_BEEF : 32'd7;
        chk($sformatf("cont.resp%0d", c/3-1), 32'(resp_valid), 32'(oh));
        chk($sformatf("cont.rdata%0d", c/3-1), resp_rdata, erd);
      end
      @(negedge clk);
    end

    // Reset during ISSUE drops the transaction.
    set_req(0, 1'b0, 32'd3, 16'd0, 32'd0);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    chk("mid.mem_en_pre", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.mem_en_async", 32'(mem_en), 32'd0);
    chk("mid.busy_async", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid.no_resp%0d", c), 32'(resp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("mid.first_contention", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("mid.mem_addr", 32'(mem_addr), 32'd3);
    repeat (2) @(negedge clk);
    chk("mid.resp_valid", 32'(resp_valid), 32'd1);
    chk("mid.resp_rdata", resp_rdata, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
